// File: rtl/fiat_25519_carry_mul_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fiat_25519_carry_mul_mac_pipe
// Brief    : Pipelined signed x unsigned limb multiplier with optional
//            burst accumulation (MODE 1). Saturating arithmetic and the
//            sticky ovf flag are enabled by the macro FIAT_MUL_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fiat_25519_carry_mul_mac_pipe #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 2,
    parameter int din0_WIDTH = 32,
    parameter int din1_WIDTH = 7,
    parameter int dout_WIDTH = 32,
    parameter int MODE       = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  acc_first,
    input  logic                  acc_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);
    localparam int c_PW    = din0_WIDTH + din1_WIDTH + 1;
    localparam int c_EW    = ((c_PW > dout_WIDTH) ? c_PW : dout_WIDTH) + 1;
    // MODE 0 folds the last product stage into the output register.
    localparam int c_DEPTH = (MODE == 1) ? NUM_STAGE : NUM_STAGE - 1;
    localparam logic [dout_WIDTH-1:0] c_MAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
    localparam logic [dout_WIDTH-1:0] c_MIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

    logic                  w_stall;
    logic                  w_in_v;
    logic [c_PW-1:0]       w_a;
    logic [c_PW-1:0]       w_b;
    logic [c_PW-1:0]       w_p;
    logic [c_EW-1:0]       w_pext;
    logic [dout_WIDTH-1:0] w_in_p;
    logic                  w_tail_v;
    logic                  w_tail_f;
    logic                  w_tail_l;
    logic [dout_WIDTH-1:0] w_tail_p;
    logic                  r_out_valid;
    logic [dout_WIDTH-1:0] r_dout;

    assign w_stall   = r_out_valid && !out_ready;
    assign in_ready  = !w_stall && ap_rst_n;
    assign w_in_v    = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign dout      = r_dout;

    assign w_a    = {{(c_PW-din0_WIDTH){din0[din0_WIDTH-1]}}, din0};
    assign w_b    = {{(c_PW-din1_WIDTH){1'b0}}, din1};
    assign w_p    = w_a * w_b;
    assign w_pext = {{(c_EW-c_PW){w_p[c_PW-1]}}, w_p};

`ifdef FIAT_MUL_SAT_EN
    logic                      w_nsat;
    logic                      w_add_sat;
    logic                      r_ovf;
    logic [c_EW-dout_WIDTH:0]  w_hi;

    // The product fits only if every bit from the result sign bit upward agrees.
    assign w_hi   = w_pext[c_EW-1:dout_WIDTH-1];
    assign w_nsat = !((&w_hi) || !(|w_hi));
    assign w_in_p = !w_nsat ? w_pext[dout_WIDTH-1:0] : (w_pext[c_EW-1] ? c_MIN : c_MAX);
    assign ovf    = r_ovf;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_ovf <= 1'b0;
        end else if ((w_in_v && w_nsat) || (!w_stall && w_tail_v && w_add_sat)) begin
            r_ovf <= 1'b1;
        end
    end
`else
    assign w_in_p = w_pext[dout_WIDTH-1:0];
    assign ovf    = 1'b0;
`endif

    generate
        if (c_DEPTH > 0) begin : g_pipe
            logic [c_DEPTH-1:0]    r_v;
            logic [c_DEPTH-1:0]    r_f;
            logic [c_DEPTH-1:0]    r_l;
            logic [dout_WIDTH-1:0] r_p [c_DEPTH];

            always_ff @(posedge ap_clk) begin
                if (!ap_rst_n) begin
                    r_v <= '0;
                end else if (!w_stall) begin
                    r_v[0] <= w_in_v;
                    r_f[0] <= acc_first;
                    r_l[0] <= acc_last;
                    r_p[0] <= w_in_p;
                    for (int i = 1; i < c_DEPTH; i++) begin
                        r_v[i] <= r_v[i-1];
                        r_f[i] <= r_f[i-1];
                        r_l[i] <= r_l[i-1];
                        r_p[i] <= r_p[i-1];
                    end
                end
            end

            assign w_tail_v = r_v[c_DEPTH-1];
            assign w_tail_f = r_f[c_DEPTH-1];
            assign w_tail_l = r_l[c_DEPTH-1];
            assign w_tail_p = r_p[c_DEPTH-1];
        end else begin : g_nopipe
            assign w_tail_v = w_in_v;
            assign w_tail_f = acc_first;
            assign w_tail_l = acc_last;
            assign w_tail_p = w_in_p;
        end

        if (MODE == 1) begin : g_mac
            logic [dout_WIDTH-1:0] r_acc;
            logic [dout_WIDTH-1:0] w_base;
            logic [dout_WIDTH-1:0] w_sum;

            // A first beat restarts from zero, so no separate load path is needed.
            assign w_base = w_tail_f ? '0 : r_acc;
`ifdef FIAT_MUL_SAT_EN
            logic [dout_WIDTH:0] w_sum_e;
            assign w_sum_e   = {w_base[dout_WIDTH-1], w_base} + {w_tail_p[dout_WIDTH-1], w_tail_p};
            assign w_add_sat = w_sum_e[dout_WIDTH] != w_sum_e[dout_WIDTH-1];
            assign w_sum     = !w_add_sat ? w_sum_e[dout_WIDTH-1:0]
                                          : (w_sum_e[dout_WIDTH] ? c_MIN : c_MAX);
`else
            assign w_sum = w_base + w_tail_p;
`endif

            always_ff @(posedge ap_clk) begin
                if (!ap_rst_n) begin
                    r_acc       <= '0;
                    r_out_valid <= 1'b0;
                    r_dout      <= '0;
                end else if (!w_stall) begin
                    if (w_tail_v) begin
                        r_acc <= w_sum;
                    end
                    r_out_valid <= w_tail_v && w_tail_l;
                    if (w_tail_v && w_tail_l) begin
                        r_dout <= w_sum;
                    end
                end
            end
        end else begin : g_mul
`ifdef FIAT_MUL_SAT_EN
            assign w_add_sat = 1'b0;
`endif
            always_ff @(posedge ap_clk) begin
                if (!ap_rst_n) begin
                    r_out_valid <= 1'b0;
                    r_dout      <= '0;
                end else if (!w_stall) begin
                    r_out_valid <= w_tail_v;
                    if (w_tail_v) begin
                        r_dout <= w_tail_p;
                    end
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fiat_25519_carry_mul_mac_pipe.sv
`default_nettype none
// Bench for fiat_25519_carry_mul_mac_pipe: MODE 0 (32-bit), MODE 1 (32-bit)
// and MODE 1 (8-bit result) instances, each scoreboarded against plain arithmetic.
module tb_fiat_25519_carry_mul_mac_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mul32(input logic [31:0] d0, input logic [6:0] d1);
        longint p;
        p = longint'($signed(d0)) * longint'({1'b0, d1});
        return p[31:0];
    endfunction

    // ---------------- instance A: MODE 0, 32-bit ----------------
    logic        a_rst_n = 1'b0, a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1, a_ovf;
    logic [31:0] a_din0 = '0, a_dout;
    logic [6:0]  a_din1 = '0;
    fiat_25519_carry_mul_mac_pipe #(.MODE(0)) u_a (
        .ap_clk(clk), .ap_rst_n(a_rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .din0(a_din0), .din1(a_din1), .acc_first(1'b0), .acc_last(1'b0),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .dout(a_dout), .ovf(a_ovf));

    // ---------------- instance B: MODE 1, 32-bit ----------------
    logic        b_rst_n = 1'b0, b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1, b_ovf;
    logic        b_first = 1'b0, b_last = 1'b0;
    logic [31:0] b_din0 = '0, b_dout;
    logic [6:0]  b_din1 = '0;
    fiat_25519_carry_mul_mac_pipe #(.MODE(1)) u_b (
        .ap_clk(clk), .ap_rst_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .din0(b_din0), .din1(b_din1), .acc_first(b_first), .acc_last(b_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .dout(b_dout), .ovf(b_ovf));

    // ---------------- instance C: MODE 1, 8-bit result ----------------
    logic        c_rst_n = 1'b0, c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b1, c_ovf;
    logic        c_first = 1'b0, c_last = 1'b0;
    logic [31:0] c_din0 = '0;
    logic [7:0]  c_dout;
    logic [6:0]  c_din1 = '0;
    fiat_25519_carry_mul_mac_pipe #(.MODE(1), .dout_WIDTH(8)) u_c (
        .ap_clk(clk), .ap_rst_n(c_rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .din0(c_din0), .din1(c_din1), .acc_first(c_first), .acc_last(c_last),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .dout(c_dout), .ovf(c_ovf));

    // ---------------- scoreboards (sampled on the falling edge) ----------------
    logic [31:0] a_q[$];
    logic [31:0] b_q[$];
    logic [31:0] b_sum = '0;
    int a_outs = 0, b_outs = 0, c_outs = 0;

    always @(negedge clk) begin
        if (!a_rst_n) a_q.delete();
        else begin
            if (a_out_valid && a_out_ready) begin
                a_outs++;
                if (a_q.size() == 0) check("a_unexpected_out", a_out_valid, 0);
                else check("a_dout", a_dout, a_q.pop_front());
            end
            if (a_in_valid && a_in_ready) a_q.push_back(mul32(a_din0, a_din1));
        end
    end

    always @(negedge clk) begin
        if (!b_rst_n) begin
            b_q.delete();
            b_sum = '0;
        end else begin
            if (b_out_valid && b_out_ready) begin
                b_outs++;
                if (b_q.size() == 0) check("b_unexpected_out", b_out_valid, 0);
                else check("b_dout", b_dout, b_q.pop_front());
            end
            if (b_in_valid && b_in_ready) begin
                b_sum = (b_first ? 32'd0 : b_sum) + mul32(b_din0, b_din1);
                if (b_last) b_q.push_back(b_sum);
            end
        end
    end

    always @(negedge clk) if (c_rst_n && c_out_valid && c_out_ready) c_outs++;

    // ---------------- drivers ----------------
    task automatic a_send(input logic [31:0] d0, input logic [6:0] d1);
        bit done = 0;
        a_in_valid = 1'b1; a_din0 = d0; a_din1 = d1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk); done = a_in_ready;
            @(posedge clk); #1;
        end
        if (!done) check("a_send_timeout", a_in_ready, 1);
    endtask

    task automatic bm_send(input bit sel, input logic [31:0] d0, input logic [6:0] d1,
                           input bit f, input bit l);
        bit done = 0;
        if (!sel) begin b_in_valid = 1'b1; b_din0 = d0; b_din1 = d1; b_first = f; b_last = l; end
        else      begin c_in_valid = 1'b1; c_din0 = d0; c_din1 = d1; c_first = f; c_last = l; end
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk); done = sel ? c_in_ready : b_in_ready;
            @(posedge clk); #1;
        end
        if (!done) check("bm_send_timeout", sel ? c_in_ready : b_in_ready, 1);
    endtask

    typedef struct { logic [31:0] d0; logic [6:0] d1; logic [31:0] exp; } vec_t;
    typedef struct { logic [31:0] d0; logic [6:0] d1; logic [7:0] exp_sat; logic [7:0] exp_wrap; bit ovf_sat; } cvec_t;
    vec_t  tab_a [7];
    cvec_t tab_c [3];
    int    base;
    bit    rnd_done;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tab_a[0] = '{32'hFFFFFFFD, 7'd127, 32'hFFFFFE83};
        tab_a[1] = '{32'h00000000, 7'd127, 32'h00000000};
        tab_a[2] = '{32'h80000000, 7'd127, 32'h80000000};
        tab_a[3] = '{32'h7FFFFFFF, 7'd127, 32'h7FFFFF81};
        tab_a[4] = '{32'hFFFFFFFF, 7'd1,   32'hFFFFFFFF};
        tab_a[5] = '{32'd1000,     7'd100, 32'h000186A0};
        tab_a[6] = '{32'd12345,    7'd0,   32'h00000000};
        tab_c[0] = '{32'hFFFFFFFB, 7'd20,  8'h9C, 8'h9C, 1'b0};
        tab_c[1] = '{32'd100,      7'd127, 8'h7F, 8'h9C, 1'b1};
        tab_c[2] = '{32'hFFFFFF9C, 7'd100, 8'h80, 8'hF0, 1'b1};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_in_ready", a_in_ready, 0);
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_a_dout", a_dout, 0);
        check("rst_b_dout", b_dout, 0);
        check("rst_c_ovf", c_ovf, 0);
        @(posedge clk); #1;
        a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_a_in_ready", a_in_ready, 1);
        @(posedge clk); #1;

        // MODE 0 latency
        a_send(32'hFFFFFFFD, 7'd127); a_in_valid = 1'b0;
        @(negedge clk); check("a_lat_c1_valid", a_out_valid, 0);
        @(negedge clk); check("a_lat_c2_valid", a_out_valid, 1);
        check("a_lat_dout", a_dout, 32'hFFFFFE83);
        @(negedge clk); check("a_lat_c3_valid", a_out_valid, 0);
        @(posedge clk); #1;

        // MODE 0 table
        for (int i = 0; i < 7; i++) begin
            a_send(tab_a[i].d0, tab_a[i].d1); a_in_valid = 1'b0;
            repeat (2) @(negedge clk);
            check("a_tab_valid", a_out_valid, 1);
            check("a_tab_dout", a_dout, tab_a[i].exp);
            @(posedge clk); #1;
        end

        // MODE 0 backpressure: out_ready low in cycles 3..6
        base = a_outs;
        fork
            begin for (int i = 0; i < 8; i++) a_send(i, 7'd5); a_in_valid = 1'b0; end
            begin
                for (int c = 0; c < 8; c++) begin
                    a_out_ready = !(c >= 3 && c <= 6);
                    @(posedge clk); #1;
                end
                a_out_ready = 1'b1;
            end
            begin repeat (5) @(negedge clk); check("a_stall_in_ready", a_in_ready, 0); end
        join
        repeat (8) @(posedge clk); #1;
        check("a_bp_count", a_outs - base, 8);
        check("a_bp_drained", a_q.size(), 0);

        // MODE 0 random traffic
        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(0, 3) == 0) begin a_in_valid = 1'b0; @(posedge clk); #1; end
                    a_send($urandom, 7'($urandom_range(0, 127)));
                end
                a_in_valid = 1'b0; rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    a_out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                a_out_ready = 1'b1;
            end
        join
        repeat (8) @(posedge clk); #1;
        check("a_rand_drained", a_q.size(), 0);

        // MODE 1 three-beat burst
        base = b_outs;
        bm_send(0, 32'd7, 7'd2, 1, 0);
        bm_send(0, 32'hFFFFFFFC, 7'd3, 0, 0);
        bm_send(0, 32'd10, 7'd1, 0, 1); b_in_valid = 1'b0;
        @(negedge clk); check("b_lat_c1_valid", b_out_valid, 0);
        @(negedge clk); check("b_lat_c2_valid", b_out_valid, 0);
        @(negedge clk); check("b_lat_c3_valid", b_out_valid, 1);
        check("b_burst_dout", b_dout, 32'd12);
        @(negedge clk); check("b_lat_c4_valid", b_out_valid, 0);
        check("b_burst_count", b_outs - base, 1);
        @(posedge clk); #1;

        // MODE 1 back-to-back bursts
        base = b_outs;
        bm_send(0, 32'd5, 7'd5, 1, 1);
        bm_send(0, 32'd1, 7'd1, 1, 0);
        bm_send(0, 32'd1, 7'd1, 0, 1); b_in_valid = 1'b0;
        repeat (6) @(posedge clk); #1;
        check("b_b2b_count", b_outs - base, 2);
        check("b_b2b_last_dout", b_dout, 32'd2);

        // MODE 1 reset mid-burst
        bm_send(0, 32'd1, 7'd2, 1, 0);
        bm_send(0, 32'd3, 7'd4, 0, 0); b_in_valid = 1'b0;
        b_rst_n = 1'b0;
        @(posedge clk); #1; b_rst_n = 1'b1;
        @(negedge clk);
        check("b_rst_out_valid", b_out_valid, 0);
        check("b_rst_dout", b_dout, 0);
        base = b_outs;
        @(posedge clk); #1;
        bm_send(0, 32'd2, 7'd3, 1, 1); b_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("b_fresh_valid", b_out_valid, 1);
        check("b_fresh_dout", b_dout, 32'd6);
        @(posedge clk); #1;
        check("b_fresh_count", b_outs - base, 1);

        // MODE 1 random bursts
        rnd_done = 0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int j = 0; j < len; j++)
                        bm_send(0, $urandom, 7'($urandom_range(0, 127)), j == 0, j == len - 1);
                    if ($urandom_range(0, 1) == 0) begin b_in_valid = 1'b0; @(posedge clk); #1; end
                end
                b_in_valid = 1'b0; rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    b_out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                b_out_ready = 1'b1;
            end
        join
        repeat (8) @(posedge clk); #1;
        check("b_rand_drained", b_q.size(), 0);

        // 8-bit accumulate: 100 + 100
        bm_send(1, 32'd100, 7'd1, 1, 0);
        bm_send(1, 32'd100, 7'd1, 0, 1); c_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("c_sum_valid", c_out_valid, 1);
`ifdef FIAT_MUL_SAT_EN
        check("c_sum_dout", c_dout, 8'h7F);
        check("c_sum_ovf", c_ovf, 1);
        repeat (5) @(negedge clk);
        check("c_ovf_sticky", c_ovf, 1);
`else
        check("c_sum_dout", c_dout, 8'hC8);
        check("c_sum_ovf", c_ovf, 0);
        repeat (5) @(negedge clk);
        check("c_ovf_tied", c_ovf, 0);
`endif
        @(posedge clk); #1; c_rst_n = 1'b0;
        @(posedge clk); #1; c_rst_n = 1'b1;
        @(negedge clk);
        check("c_rst_ovf", c_ovf, 0);
        check("c_rst_dout", c_dout, 0);
        @(posedge clk); #1;

        // 8-bit narrowing of single products
        base = c_outs;
        for (int i = 0; i < 3; i++) begin
            bm_send(1, tab_c[i].d0, tab_c[i].d1, 1, 1); c_in_valid = 1'b0;
            repeat (3) @(negedge clk);
            check("c_tab_valid", c_out_valid, 1);
`ifdef FIAT_MUL_SAT_EN
            check("c_tab_dout", c_dout, tab_c[i].exp_sat);
            check("c_tab_ovf", c_ovf, tab_c[i].ovf_sat);
`else
            check("c_tab_dout", c_dout, tab_c[i].exp_wrap);
            check("c_tab_ovf", c_ovf, 0);
`endif
            @(posedge clk); #1;
        end
        repeat (2) @(posedge clk); #1;
        check("c_tab_count", c_outs - base, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fiat_25519_carry_mul_mac_pipe.md
Name: fiat_25519_carry_mul_mac_pipe

Overview:
- Pipelined signed×unsigned multiplier and multiply-accumulate unit for the fiat_25519 carry_mul limb datapath.
- Successor to the combinational 32s×7ns multiplier cores: parametrised operand widths, configurable pipeline depth, valid/ready handshake with backpressure, optional accumulation of limb products.
- Sits between the limb-operand fetch logic and the carry-reduction stage.

Parameters:
- ID, 1, instance tag; no functional effect.
- NUM_STAGE, 2, product pipeline registers; legal range 1..4.
- din0_WIDTH, 32, width of signed operand din0.
- din1_WIDTH, 7, width of unsigned operand din1.
- dout_WIDTH, 32, result and accumulator width.
- MODE, 0, 0 = one result per product; 1 = accumulate a burst of products into one result.

Ports:
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat.
- din0  in  din0_WIDTH  signed operand.
- din1  in  din1_WIDTH  unsigned operand, zero-extended by 1 bit before multiply.
- acc_first  in  1  MODE 1 only: beat starts a new sum; ignored in MODE 0.
- acc_last  in  1  MODE 1 only: beat ends the sum; ignored in MODE 0.
- out_valid  out  1  dout holds a result.
- out_ready  in  1  downstream accepts the result.
- dout  out  dout_WIDTH  signed result.
- ovf  out  1  sticky overflow flag; see Optional Feature.

Behaviour:
- Reset (ap_rst_n = 0 at a rising edge): all stage valid bits cleared, accumulator = 0, out_valid = 0, dout = 0, ovf = 0. in_ready is 0 during reset and 1 on the first cycle after it.
- Accept: a beat transfers when in_valid && in_ready.
- Stall: stall = out_valid && !out_ready. in_ready = !stall && ap_rst_n.
  - While stall is high, every pipeline register, the accumulator, dout and out_valid hold their values.
- Arithmetic:
  - Full product p = $signed(din0) * $signed({1'b0, din1}), width din0_WIDTH+din1_WIDTH+1.
  - p is sign-extended or truncated to dout_WIDTH, keeping the low bits.
  - All sums wrap modulo 2^dout_WIDTH unless the macro is enabled.
- MODE 0: result for an accepted beat appears with out_valid = 1 exactly NUM_STAGE cycles after acceptance, absent stalls. Full throughput is one beat per cycle. Result order equals input order.
- MODE 1: the product reaches the accumulate stage after NUM_STAGE cycles.
  - Beat with acc_first = 1: acc = p, discarding the prior sum.
  - Beat with acc_first = 0: acc = acc + p.
  - Beat with acc_last = 1: the updated sum is loaded to dout and out_valid = 1. Latency is NUM_STAGE+1 from acceptance of the last beat.
  - Beat with acc_first = acc_last = 1: single-product result, dout = p.
  - Beats without acc_last produce no output.
  - A first beat following a last beat with no gap is legal: back-to-back bursts run at full rate.
- out_valid falls on the cycle after out_valid && out_ready unless a new result arrives in that same cycle, in which case out_valid stays 1 and dout updates.
- Reset asserted mid-burst or mid-stall discards all in-flight beats and the partial sum. No output is produced for discarded beats.

Optional Feature:
- Macro FIAT_MUL_SAT_EN.
- Defined: each add, and the final narrowing of p, saturates to [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1]. ovf is set on any saturation and stays set until reset.
- Undefined: results wrap modulo 2^dout_WIDTH and ovf is tied to 0.

Test Plan:
- MODE 0, NUM_STAGE=2, din0=-3, din1=127, out_ready=1 -> out_valid high 2 cycles after accept, dout=-381 (0xFFFFFE83).
- MODE 0, 8 back-to-back beats din0=i, din1=5, i=0..7, with out_ready held 0 from cycle 3 to 6 -> in_ready=0 during the stall; outputs 0,5,...,35 in order with no loss or duplicate.
- MODE 1, beats (7,2,first), (-4,3), (10,1,last) -> single out_valid NUM_STAGE+1 cycles after the last beat, dout=12; no output for the other beats.
- MODE 1, burst (5,5,first,last) immediately followed by (1,1,first),(1,1,last) -> two results 25 then 2, back-to-back.
- MODE 1, ap_rst_n pulled low for 1 cycle after the second beat of a 4-beat burst -> out_valid=0 and dout=0 after reset; a fresh burst (2,3,first,last) gives 6.
- FIAT_MUL_SAT_EN defined, dout_WIDTH=8, MODE 1, beats (100,1,first),(100,1,last) -> dout=127 and ovf=1, held until reset. Same stimulus with the macro undefined -> dout=-56 and ovf=0.
